// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing package: default 640x480 timing, width limits,
// character cell sizes and the vga_timing_t description for downstream blocks.
package vga_timing_gen_pkg;

  localparam int unsigned VGA_HD = 640;
  localparam int unsigned VGA_HF = 16;
  localparam int unsigned VGA_HR = 96;
  localparam int unsigned VGA_HB = 48;

  localparam int unsigned VGA_VD = 480;
  localparam int unsigned VGA_VF = 10;
  localparam int unsigned VGA_VR = 2;
  localparam int unsigned VGA_VB = 33;

  localparam int unsigned VGA_CLK_DIV = 4;

  localparam int unsigned VGA_CELL_H_PIXELS = 8;
  localparam int unsigned VGA_CELL_V_PIXELS = 16;

  // Field widths of vga_timing_t; wide enough for common modes
  // up to 4095 pixels/lines per segment.
  localparam int unsigned VGA_MAX_H_WIDTH = 12;
  localparam int unsigned VGA_MAX_V_WIDTH = 12;

  typedef struct packed {
    logic [VGA_MAX_H_WIDTH-1:0] hd;
    logic [VGA_MAX_H_WIDTH-1:0] hf;
    logic [VGA_MAX_H_WIDTH-1:0] hr;
    logic [VGA_MAX_H_WIDTH-1:0] hb;
    logic [VGA_MAX_V_WIDTH-1:0] vd;
    logic [VGA_MAX_V_WIDTH-1:0] vf;
    logic [VGA_MAX_V_WIDTH-1:0] vr;
    logic [VGA_MAX_V_WIDTH-1:0] vb;
  } vga_timing_t;

  localparam vga_timing_t VGA_TIMING_640X480 = '{
    hd: VGA_MAX_H_WIDTH'(VGA_HD),
    hf: VGA_MAX_H_WIDTH'(VGA_HF),
    hr: VGA_MAX_H_WIDTH'(VGA_HR),
    hb: VGA_MAX_H_WIDTH'(VGA_HB),
    vd: VGA_MAX_V_WIDTH'(VGA_VD),
    vf: VGA_MAX_V_WIDTH'(VGA_VF),
    vr: VGA_MAX_V_WIDTH'(VGA_VR),
    vb: VGA_MAX_V_WIDTH'(VGA_VB)
  };

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_strobe.sv
// Pixel strobe divider: counts enabled clocks 0..CLK_DIV-1, adv_o marks the last.
// Ports: clk_i, arstn_i (async low), en_i (hold when low), adv_o (advance pulse).
module vga_pix_strobe
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic en_i,
  output logic adv_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;

  // With CLK_DIV=1 div_q stays 0 and every enabled edge advances.
  assign adv_o = en_i && (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_q <= '0;
    end else if (adv_o) begin
      div_q <= '0;
    end else if (en_i) begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel strobe, h/v counters, registered
// sync/de/markers and character cell coordinates, all updated on the strobe.
// Ports: clk_i, arstn_i, en_i in; pix_stb_o, hcount_o, vcount_o, hsync_o,
// vsync_o, de_o, line_start_o, frame_start_o, cell_x/y_o, sub_x/y_o out.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned HD            = VGA_HD,
  parameter int unsigned HF            = VGA_HF,
  parameter int unsigned HR            = VGA_HR,
  parameter int unsigned HB            = VGA_HB,
  parameter int unsigned VD            = VGA_VD,
  parameter int unsigned VF            = VGA_VF,
  parameter int unsigned VR            = VGA_VR,
  parameter int unsigned VB            = VGA_VB,
  parameter bit          H_SYNC_POL    = 1'b0,
  parameter bit          V_SYNC_POL    = 1'b0,
  parameter int unsigned CLK_DIV       = VGA_CLK_DIV,
  parameter int unsigned CELL_H_PIXELS = VGA_CELL_H_PIXELS,
  parameter int unsigned CELL_V_PIXELS = VGA_CELL_V_PIXELS,
  localparam int unsigned HTOTAL = HD + HF + HR + HB,
  localparam int unsigned VTOTAL = VD + VF + VR + VB,
  localparam int unsigned HW  = $clog2(HTOTAL),
  localparam int unsigned VW  = $clog2(VTOTAL),
  localparam int unsigned CXW = $clog2(HD / CELL_H_PIXELS),
  localparam int unsigned CYW = $clog2(VD / CELL_V_PIXELS),
  localparam int unsigned SXW = $clog2(CELL_H_PIXELS),
  localparam int unsigned SYW = $clog2(CELL_V_PIXELS)
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  input  logic           en_i,
  output logic           pix_stb_o,
  output logic [HW-1:0]  hcount_o,
  output logic [VW-1:0]  vcount_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           de_o,
  output logic           line_start_o,
  output logic           frame_start_o,
  output logic [CXW-1:0] cell_x_o,
  output logic [CYW-1:0] cell_y_o,
  output logic [SXW-1:0] sub_x_o,
  output logic [SYW-1:0] sub_y_o
);

  if (HF == 0 || HR == 0 || HB == 0 || VF == 0 || VR == 0 || VB == 0) begin : g_err_porch
    $error("vga_timing_gen: porch and sync widths must be nonzero");
  end
  if (CLK_DIV == 0) begin : g_err_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (!is_pow2(CELL_H_PIXELS) || !is_pow2(CELL_V_PIXELS)) begin : g_err_cell
    $error("vga_timing_gen: cell sizes must be powers of two");
  end

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_DISP = HW'(HD);
  localparam logic [HW-1:0] HS_BEG = HW'(HD + HF);
  localparam logic [HW-1:0] HS_END = HW'(HD + HF + HR - 1);

  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_DISP = VW'(VD);
  localparam logic [VW-1:0] VS_BEG = VW'(VD + VF);
  localparam logic [VW-1:0] VS_END = VW'(VD + VF + VR - 1);

  logic          adv;
  logic          h_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          hs_act;
  logic          vs_act;
  logic          de_nxt;

  vga_pix_strobe #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_strobe (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .en_i   (en_i),
    .adv_o  (adv)
  );

  always_comb begin
    h_wrap = (hcount_o == H_LAST);
    h_nxt  = h_wrap ? '0 : hcount_o + HW'(1);
    v_nxt  = vcount_o;
    if (h_wrap) begin
      v_nxt = (vcount_o == V_LAST) ? '0 : vcount_o + VW'(1);
    end
  end

  // Decode from the next counts so the registered flags line up
  // with the registered counters.
  always_comb begin
    hs_act = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
    vs_act = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
    de_nxt = (h_nxt < H_DISP) && (v_nxt < V_DISP);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pix_stb_o     <= 1'b0;
      hcount_o      <= H_LAST;
      vcount_o      <= V_LAST;
      hsync_o       <= !H_SYNC_POL;
      vsync_o       <= !V_SYNC_POL;
      de_o          <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      cell_x_o      <= '0;
      cell_y_o      <= '0;
      sub_x_o       <= '0;
      sub_y_o       <= '0;
    end else begin
      // Markers are single-strobe pulses; they drop with the strobe.
      pix_stb_o     <= adv;
      line_start_o  <= adv && (h_nxt == '0);
      frame_start_o <= adv && (h_nxt == '0) && (v_nxt == '0);
      if (adv) begin
        hcount_o <= h_nxt;
        vcount_o <= v_nxt;
        hsync_o  <= hs_act ? H_SYNC_POL : !H_SYNC_POL;
        vsync_o  <= vs_act ? V_SYNC_POL : !V_SYNC_POL;
        de_o     <= de_nxt;
        cell_x_o <= h_nxt[SXW +: CXW];
        cell_y_o <= v_nxt[SYW +: CYW];
        sub_x_o  <= h_nxt[SXW-1:0];
        sub_y_o  <= v_nxt[SYW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations against an arithmetic
// raster model indexed by enabled-cycle count, plus literal spot checks.
module tb_vga_timing_gen;

  typedef struct {
    int stb, h, v, hs, vs, de, ls, fs, cx, cy, sx, sy;
  } obs_t;

  typedef struct {
    int hd, hf, hr, hb, vd, vf, vr, vb, div, hpol, vpol, cw, ch;
  } cfg_t;

  cfg_t c1 = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0, 0, 8, 16};
  cfg_t c2 = '{16, 2, 2, 2, 8, 1, 1, 1, 1, 1, 0, 8, 4};
  cfg_t c3 = '{64, 4, 8, 4, 48, 2, 2, 4, 2, 0, 1, 8, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;

  always #5 clk = ~clk;

  logic       stb1, hs1, vs1, de1, ls1, fs1;
  logic [9:0] h1, v1;
  logic [6:0] cx1;
  logic [4:0] cy1;
  logic [2:0] sx1;
  logic [3:0] sy1;

  logic       stb2, hs2, vs2, de2, ls2, fs2;
  logic [4:0] h2;
  logic [3:0] v2;
  logic [0:0] cx2, cy2;
  logic [2:0] sx2;
  logic [1:0] sy2;

  logic       stb3, hs3, vs3, de3, ls3, fs3;
  logic [6:0] h3;
  logic [5:0] v3;
  logic [2:0] cx3, sx3;
  logic [1:0] cy3;
  logic [3:0] sy3;

  vga_timing_gen dut (
    .clk_i(clk), .arstn_i(rst_n), .en_i(en1),
    .pix_stb_o(stb1), .hcount_o(h1), .vcount_o(v1),
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1),
    .line_start_o(ls1), .frame_start_o(fs1),
    .cell_x_o(cx1), .cell_y_o(cy1), .sub_x_o(sx1), .sub_y_o(sy1)
  );

  vga_timing_gen #(
    .HD(16), .HF(2), .HR(2), .HB(2),
    .VD(8), .VF(1), .VR(1), .VB(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CLK_DIV(1),
    .CELL_H_PIXELS(8), .CELL_V_PIXELS(4)
  ) dut2 (
    .clk_i(clk), .arstn_i(rst_n), .en_i(en2),
    .pix_stb_o(stb2), .hcount_o(h2), .vcount_o(v2),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2),
    .line_start_o(ls2), .frame_start_o(fs2),
    .cell_x_o(cx2), .cell_y_o(cy2), .sub_x_o(sx2), .sub_y_o(sy2)
  );

  vga_timing_gen #(
    .HD(64), .HF(4), .HR(8), .HB(4),
    .VD(48), .VF(2), .VR(2), .VB(4),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CLK_DIV(2),
    .CELL_H_PIXELS(8), .CELL_V_PIXELS(16)
  ) dut3 (
    .clk_i(clk), .arstn_i(rst_n), .en_i(en3),
    .pix_stb_o(stb3), .hcount_o(h3), .vcount_o(v3),
    .hsync_o(hs3), .vsync_o(vs3), .de_o(de3),
    .line_start_o(ls3), .frame_start_o(fs3),
    .cell_x_o(cx3), .cell_y_o(cy3), .sub_x_o(sx3), .sub_y_o(sy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Raster position is purely a function of how many enabled edges
  // have elapsed since reset: pixel index = advances - 1 (mod frame).
  function automatic obs_t model(input cfg_t c, input longint n, input bit last_en);
    obs_t o;
    longint ht, vt, tot, a, p;
    int h, v;
    ht  = c.hd + c.hf + c.hr + c.hb;
    vt  = c.vd + c.vf + c.vr + c.vb;
    tot = ht * vt;
    a   = n / c.div;
    p   = (a + tot - 1) % tot;
    h   = int'(p % ht);
    v   = int'(p / ht);
    o.stb = (last_en && n > 0 && (n % c.div) == 0) ? 1 : 0;
    o.h   = h;
    o.v   = v;
    o.hs  = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hr) ? c.hpol : 1 - c.hpol;
    o.vs  = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vr) ? c.vpol : 1 - c.vpol;
    o.de  = (h < c.hd && v < c.vd) ? 1 : 0;
    o.ls  = (o.stb == 1 && h == 0) ? 1 : 0;
    o.fs  = (o.stb == 1 && h == 0 && v == 0) ? 1 : 0;
    o.cx  = h / c.cw;
    o.cy  = v / c.ch;
    o.sx  = h % c.cw;
    o.sy  = v % c.ch;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    chk({nm, ".stb"}, a.stb, e.stb);
    chk({nm, ".h"}, a.h, e.h);
    chk({nm, ".v"}, a.v, e.v);
    chk({nm, ".hs"}, a.hs, e.hs);
    chk({nm, ".vs"}, a.vs, e.vs);
    chk({nm, ".de"}, a.de, e.de);
    chk({nm, ".ls"}, a.ls, e.ls);
    chk({nm, ".fs"}, a.fs, e.fs);
    if (e.de == 1) begin
      chk({nm, ".cx"}, a.cx, e.cx);
      chk({nm, ".cy"}, a.cy, e.cy);
      chk({nm, ".sx"}, a.sx, e.sx);
      chk({nm, ".sy"}, a.sy, e.sy);
    end
  endtask

  longint n1, n2, n3;
  bit le1, le2, le3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n1 <= 0; n2 <= 0; n3 <= 0;
      le1 <= 1'b0; le2 <= 1'b0; le3 <= 1'b0;
    end else begin
      le1 <= en1; le2 <= en2; le3 <= en3;
      if (en1) n1 <= n1 + 1;
      if (en2) n2 <= n2 + 1;
      if (en3) n3 <= n3 + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      cmp("d1", '{int'(stb1), int'(h1), int'(v1), int'(hs1), int'(vs1),
                  int'(de1), int'(ls1), int'(fs1), int'(cx1), int'(cy1),
                  int'(sx1), int'(sy1)}, model(c1, n1, le1));
      cmp("d2", '{int'(stb2), int'(h2), int'(v2), int'(hs2), int'(vs2),
                  int'(de2), int'(ls2), int'(fs2), int'(cx2), int'(cy2),
                  int'(sx2), int'(sy2)}, model(c2, n2, le2));
      cmp("d3", '{int'(stb3), int'(h3), int'(v3), int'(hs3), int'(vs3),
                  int'(de3), int'(ls3), int'(fs3), int'(cx3), int'(cy3),
                  int'(sx3), int'(sy3)}, model(c3, n3, le3));
    end
  end

  bit steady = 1'b0;
  int last_ls1 = -1, last_fs2 = -1, last_fs3 = -1;
  int hs_min = 99999, hs_max = -1, de_min = 99999, de_max = -1;

  always @(negedge clk) begin
    if (steady && rst_n) begin
      if (ls1) begin
        if (last_ls1 >= 0) chk("ls1_period", cyc - last_ls1, 3200);
        last_ls1 = cyc;
      end
      if (fs2) begin
        if (last_fs2 >= 0) chk("fs2_period", cyc - last_fs2, 242);
        last_fs2 = cyc;
      end
      if (fs3) begin
        if (last_fs3 >= 0) chk("fs3_period", cyc - last_fs3, 8960);
        last_fs3 = cyc;
      end
      if (stb1 && v1 < 10'd480) begin
        if (!hs1) begin
          if (int'(h1) < hs_min) hs_min = int'(h1);
          if (int'(h1) > hs_max) hs_max = int'(h1);
        end
        if (!de1) begin
          if (int'(h1) < de_min) de_min = int'(h1);
          if (int'(h1) > de_max) de_max = int'(h1);
        end
      end
    end
  end

  initial begin
    int k;
    int stb_seen;
    repeat (3) @(negedge clk);
    chk("rst.h1", int'(h1), 799);
    chk("rst.v1", int'(v1), 524);
    chk("rst.hs1", int'(hs1), 1);
    chk("rst.vs1", int'(vs1), 1);
    chk("rst.de1", int'(de1), 0);
    chk("rst.stb1", int'(stb1), 0);
    chk("rst.fs1", int'(fs1), 0);
    chk("rst.cx1", int'(cx1), 0);
    chk("rst.hs2", int'(hs2), 0);
    chk("rst.vs3", int'(vs3), 0);

    rst_n = 1'b1;
    en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    cmp_on = 1'b1;
    steady = 1'b1;

    repeat (3) @(negedge clk);
    chk("edge3.stb1", int'(stb1), 0);
    chk("edge3.h1", int'(h1), 799);
    @(negedge clk);
    chk("edge4.stb1", int'(stb1), 1);
    chk("edge4.h1", int'(h1), 0);
    chk("edge4.v1", int'(v1), 0);
    chk("edge4.de1", int'(de1), 1);
    chk("edge4.fs1", int'(fs1), 1);
    chk("edge4.ls1", int'(ls1), 1);
    chk("edge4.stb2", int'(stb2), 1);

    k = 0;
    while (!(stb3 && h3 == 7'd17 && v3 == 6'd35) && k < 8000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 8000) begin
      chk("cell.timeout", 0, 1);
    end else begin
      chk("cell.cx3", int'(cx3), 2);
      chk("cell.cy3", int'(cy3), 2);
      chk("cell.sx3", int'(sx3), 1);
      chk("cell.sy3", int'(sy3), 3);
    end

    while (cyc < 9800) @(negedge clk);
    steady = 1'b0;
    chk("hsync_first", hs_min, 656);
    chk("hsync_last", hs_max, 751);
    chk("blank_first", de_min, 640);
    chk("blank_last", de_max, 799);

    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    stb_seen = 0;
    repeat (37) begin
      @(negedge clk);
      stb_seen += int'(stb1) + int'(stb2) + int'(stb3);
    end
    chk("freeze.stb", stb_seen, 0);
    en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;

    repeat (6000) begin
      @(negedge clk);
      en1 = ($urandom_range(9) != 0);
      en2 = ($urandom_range(9) != 0);
      en3 = ($urandom_range(3) != 0);
    end

    en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    k = 0;
    while (!(stb3 && h3 == 7'd30 && v3 == 6'd20) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) begin
      chk("midreset.timeout", 0, 1);
    end else begin
      #2 rst_n = 1'b0;
      #1;
      chk("arst.h3", int'(h3), 79);
      chk("arst.v3", int'(v3), 55);
      chk("arst.stb3", int'(stb3), 0);
      chk("arst.de3", int'(de3), 0);
      chk("arst.hs3", int'(hs3), 1);
      chk("arst.vs3", int'(vs3), 0);
      chk("arst.cx3", int'(cx3), 0);
      chk("arst.h1", int'(h1), 799);
      chk("arst.hs2", int'(hs2), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end

    repeat (3000) begin
      @(negedge clk);
      en1 = ($urandom_range(7) != 0);
      en2 = ($urandom_range(7) != 0);
      en3 = ($urandom_range(7) != 0);
    end

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
